// File: rtl/psum_accum_fp16.sv
// Partial-sum reduction for one systolic column: sums each FP16 packet into a single
// result through a one-stage FP16 adder whose output is fed back into the accumulator.

module add_fp16 (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] fp1_in,
  input  logic [15:0] fp2_in,
  output logic [15:0] fp_out
);
  logic [15:0] x, y, sum_c;
  logic [5:0]  ex, ey, e, de;
  logic [4:0]  d, lz, shl;
  logic [13:0] ax, ay, ays, n;
  logic [27:0] sh;
  logic [14:0] s;
  logic [11:0] mr;
  logic        up, sg;

  always_comb begin
    // x always holds the larger magnitude so the subtract never goes negative
    if (fp1_in[14:0] >= fp2_in[14:0]) begin
      x = fp1_in; y = fp2_in;
    end else begin
      x = fp2_in; y = fp1_in;
    end
    ex  = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
    ey  = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
    ax  = {(x[14:10] != 5'd0), x[9:0], 3'b000};
    ay  = {(y[14:10] != 5'd0), y[9:0], 3'b000};
    de  = ex - ey;
    d   = (de > 6'd15) ? 5'd15 : de[4:0];
    sh  = {ay, 14'd0} >> d;
    ays = sh[27:14] | {13'd0, |sh[13:0]};
    s   = (x[15] == y[15]) ? ({1'b0, ax} + {1'b0, ays}) : ({1'b0, ax} - {1'b0, ays});
    sg  = (s == 15'd0 && x[15] != y[15]) ? 1'b0 : x[15];

    lz  = 5'd0;
    shl = 5'd0;
    if (s[14]) begin
      n = s[14:1] | {13'd0, s[0]};
      e = ex + 6'd1;
    end else begin
      for (int i = 0; i < 14; i++)
        if (s[i]) lz = 5'(13 - i);
      // never normalise below the minimum exponent: the result goes subnormal instead
      shl = ({1'b0, lz} > ex - 6'd1) ? 5'(ex - 6'd1) : lz;
      n   = s[13:0] << shl;
      e   = ex - {1'b0, shl};
    end

    up = n[2] & ((|n[1:0]) | n[3]);
    mr = {1'b0, n[13:3]} + {11'd0, up};
    if (mr[11]) begin
      mr = mr >> 1;
      e  = e + 6'd1;
    end

    if (e >= 6'd31) sum_c = {sg, 5'h1F, 10'd0};
    else            sum_c = {sg, (mr[10] ? e[4:0] : 5'd0), mr[9:0]};

    if (x[14:10] == 5'h1F) begin
      if (x[9:0] != 10'd0 || (y[14:0] == 15'h7C00 && x[15] != y[15])) sum_c = 16'h7E00;
      else                                                             sum_c = x;
    end
  end

  always_ff @(posedge clk or negedge nRST)
    if (!nRST)      fp_out <= 16'h0000;
    else if (start) fp_out <= sum_c;
endmodule

module psum_accum_fp16 #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_len,
  output logic             out_trunc
);
  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, fp_out;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             last_q, trunc_q, accept, hit_max;

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign hit_max  = (cnt_inc == CNT_W'(MAX_LEN));

  add_fp16 u_add (
    .clk    (clk),
    .nRST   (nRST),
    .start  (1'b1),
    .fp1_in (acc_q),
    .fp2_in (in_data),
    .fp_out (fp_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_last || MAX_LEN == 1) ? DONE : ACC;
      ACC:  if (accept) state_d = WAIT;
      WAIT: state_d = last_q ? DONE : ACC;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST)
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          // first beat bypasses the adder
          acc_q   <= in_data;
          cnt_q   <= CNT_W'(1);
          last_q  <= in_last || (MAX_LEN == 1);
          trunc_q <= ~in_last && (MAX_LEN == 1);
        end
        ACC: if (accept) begin
          cnt_q   <= cnt_inc;
          last_q  <= in_last | hit_max;
          trunc_q <= ~in_last & hit_max;
        end
        WAIT: acc_q <= fp_out;
        DONE: if (out_ready) begin
          cnt_q   <= '0;
          last_q  <= 1'b0;
          trunc_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign out_len   = cnt_q;
  assign out_trunc = trunc_q;
endmodule

// File: tb/tb_psum_accum_fp16.sv
// Directed bench for psum_accum_fp16 built with MAX_LEN=4: table of packets plus
// hand sequences for truncation, output backpressure and mid-packet reset.

module tb_psum_accum_fp16;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          in_valid, in_ready, in_last;
  logic [15:0]   in_data;
  logic          out_valid, out_ready, out_trunc;
  logic [15:0]   out_data;
  logic [CW-1:0] out_len;

  always #5 clk = ~clk;

  psum_accum_fp16 #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_trunc (out_trunc)
  );

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int              n;
    logic [3:0][15:0] b;
    logic [15:0]     ed;
    int              el;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input int n, input logic [15:0] b0, b1, b2, b3,
                              input logic [15:0] ed, input int el);
    vec_t v;
    v.n = n; v.b = {b3, b2, b1, b0}; v.ed = ed; v.el = el;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic push(input logic [15:0] d, input logic l);
    int k = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input string nm, input logic [15:0] d, input int len, input logic tr);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_data"},  32'(out_data),  32'(d));
    check({nm, "_len"},   32'(out_len),   32'(len));
    check({nm, "_trunc"}, 32'(out_trunc), 32'(tr));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_len",   32'(out_len),   32'd0);
    check("rst_out_trunc", 32'(out_trunc), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    nRST = 1'b1;
    @(negedge clk);

    tbl[0] = mk(1, 16'h3C00, 16'h0,    16'h0,    16'h0,    16'h3C00, 1); // 1.0
    tbl[1] = mk(3, 16'h3C00, 16'h4000, 16'h3800, 16'h0,    16'h4300, 3); // 1+2+0.5
    tbl[2] = mk(2, 16'h7BFF, 16'h7BFF, 16'h0,    16'h0,    16'h7C00, 2); // overflow to inf
    tbl[3] = mk(2, 16'h4200, 16'hBC00, 16'h0,    16'h0,    16'h4000, 2); // 3 + -1
    tbl[4] = mk(2, 16'h3C00, 16'hBC00, 16'h0,    16'h0,    16'h0000, 2); // exact cancel
    tbl[5] = mk(4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400, 4); // last at MAX_LEN
    tbl[6] = mk(1, 16'hC000, 16'h0,    16'h0,    16'h0,    16'hC000, 1); // -2.0
    tbl[7] = mk(2, 16'h3C00, 16'h1000, 16'h0,    16'h0,    16'h3C00, 2); // tie, stays even
    tbl[8] = mk(2, 16'h3C01, 16'h1000, 16'h0,    16'h0,    16'h3C02, 2); // tie, rounds up
    tbl[9] = mk(2, 16'h4000, 16'hBE00, 16'h0,    16'h0,    16'h3800, 2); // 2 - 1.5

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        push(tbl[v].b[i], i == tbl[v].n - 1);
        if (i > 0) check("ready_low_in_wait", 32'(in_ready), 32'd0);
      end
      if (tbl[v].n == 1) begin
        check("lat1_valid", 32'(out_valid), 32'd1);
      end else begin
        check("lat2_not_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat2_valid", 32'(out_valid), 32'd1);
      end
      collect($sformatf("vec%0d", v), tbl[v].ed, tbl[v].el, 1'b0);
    end

    // force-close at MAX_LEN, then the following beats form a new packet
    for (int i = 0; i < 4; i++) push(16'h3C00, 1'b0);
    check("trunc_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    collect("trunc", 16'h4400, 4, 1'b1);
    push(16'h3C00, 1'b0);
    push(16'h4000, 1'b1);
    collect("after_trunc", 16'h4200, 2, 1'b0);

    // output backpressure with a pending input beat
    push(16'h4000, 1'b1);
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_data",     32'(out_data),  32'h4000);
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    check("hold_len", 32'(out_len), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",   32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    collect("pending", 16'h3C00, 1, 1'b0);

    // reset while the second beat's add is in flight
    push(16'h3C00, 1'b0);
    push(16'h4000, 1'b0);
    nRST = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_out_len",   32'(out_len),   32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    push(16'h3C00, 1'b0);
    push(16'h3C00, 1'b1);
    collect("post_rst", 16'h4000, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
